// File: rtl/axil_axis_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axil_axis_responder_if : AXI-Lite slave + AXI-Stream sink/source bus |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface axil_axis_responder_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   wvalid;
  logic                   wready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   arvalid;
  logic                   arready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   rvalid;
  logic                   rready;
  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;
  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, araddr, arvalid, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  awready, wready, arready, rdata, rvalid, ss_tready,
           sm_tvalid, sm_tdata, sm_tlast
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, araddr, arvalid, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output awready, wready, arready, rdata, rvalid, ss_tready,
           sm_tvalid, sm_tdata, sm_tlast
  );
endinterface
`default_nettype wire

// File: rtl/axil_axis_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axil_axis_responder : AXI-Lite register bank + offset-adding stream  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module axil_axis_responder #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pFIFO_DEPTH = 4
) (
  input wire logic             axis_clk,
  input wire logic             axis_rst_n,
  axil_axis_responder_if.slave bus
);
  localparam int c_PTR_W = $clog2(pFIFO_DEPTH);
  localparam logic [7:0] c_ADDR_CTRL   = 8'h00;
  localparam logic [7:0] c_ADDR_LENGTH = 8'h10;
  localparam logic [7:0] c_ADDR_OFFSET = 8'h14;
  localparam logic [7:0] c_ADDR_COUNT  = 8'h18;
  localparam logic [c_PTR_W:0]     c_FULL    = (c_PTR_W+1)'(pFIFO_DEPTH);
  localparam logic [c_PTR_W:0]     c_CNT_ONE = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
  localparam logic [pDATA_WIDTH-1:0] c_DATA_ONE = pDATA_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   awready_q;
  logic                   arready_q;
  logic                   rvalid_q;
  logic [pDATA_WIDTH-1:0] rdata_q;
  logic [7:0]             rd_addr_q;
  logic                   ap_idle_q;
  logic                   ap_done_q;
  logic [pDATA_WIDTH-1:0] length_q;
  logic [pDATA_WIDTH-1:0] offset_q;
  logic [pDATA_WIDTH-1:0] count_q;

  logic [pDATA_WIDTH:0]   mem_q [pFIFO_DEPTH];
  logic [c_PTR_W-1:0]     wr_ptr_q;
  logic [c_PTR_W-1:0]     rd_ptr_q;
  logic [c_PTR_W:0]       fifo_cnt_q;
  logic [c_PTR_W:0]       fifo_cnt_d;

  logic                   w_wr_fire;
  logic [7:0]             w_wr_addr;
  logic                   w_rd_fire;
  logic                   w_rd_done;
  logic [pDATA_WIDTH-1:0] w_rd_data;
  logic                   w_ss_tready;
  logic                   w_sm_tvalid;
  logic [pDATA_WIDTH:0]   w_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_unused_addr;

  assign w_wr_fire   = bus.awvalid && bus.wvalid && !awready_q;
  assign w_wr_addr   = bus.awaddr[7:0];
  assign w_rd_fire   = bus.arvalid && arready_q;
  assign w_rd_done   = rvalid_q && bus.rready;
  assign w_ss_tready = (state_q == S_RUN) && (fifo_cnt_q < c_FULL);
  assign w_sm_tvalid = (fifo_cnt_q != '0);
  assign w_head      = mem_q[rd_ptr_q];
  assign w_push      = bus.ss_tvalid && w_ss_tready;
  assign w_pop       = w_sm_tvalid && bus.sm_tready;
  assign w_unused_addr = ^{bus.awaddr[pADDR_WIDTH-1:8], bus.araddr[pADDR_WIDTH-1:8]};

  assign bus.awready   = awready_q;
  assign bus.wready    = awready_q;
  assign bus.arready   = arready_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.ss_tready = w_ss_tready;
  assign bus.sm_tvalid = w_sm_tvalid;
  // Gate the head so an empty FIFO presents zeros rather than stale entries
  assign bus.sm_tdata  = w_sm_tvalid ? (w_head[pDATA_WIDTH-1:0] + offset_q) : '0;
  assign bus.sm_tlast  = w_sm_tvalid && w_head[pDATA_WIDTH];

  always_comb begin
    w_rd_data = '0;
    case (bus.araddr[7:0])
      c_ADDR_CTRL:   w_rd_data = {{(pDATA_WIDTH-3){1'b0}}, ap_idle_q, ap_done_q, 1'b0};
      c_ADDR_LENGTH: w_rd_data = length_q;
      c_ADDR_OFFSET: w_rd_data = offset_q;
      c_ADDR_COUNT:  w_rd_data = count_q;
      default:       w_rd_data = '0;
    endcase
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (w_push && !w_pop) begin
      fifo_cnt_d = fifo_cnt_q + c_CNT_ONE;
    end else if (!w_push && w_pop) begin
      fifo_cnt_d = fifo_cnt_q - c_CNT_ONE;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {bus.ss_tlast, bus.ss_tdata};
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rd_addr_q <= '0;
      ap_idle_q <= 1'b1;
      ap_done_q <= 1'b0;
      length_q  <= '0;
      offset_q  <= '0;
      count_q   <= '0;
    end else begin
      awready_q <= w_wr_fire;

      if (w_rd_fire) begin
        arready_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rdata_q   <= w_rd_data;
        rd_addr_q <= bus.araddr[7:0];
      end else if (w_rd_done) begin
        rvalid_q  <= 1'b0;
        arready_q <= 1'b1;
      end else if (!rvalid_q) begin
        arready_q <= 1'b1;
      end

      // The returned word already carries ap_done; completing the read clears it
      if (w_rd_done && rd_addr_q == c_ADDR_CTRL) ap_done_q <= 1'b0;

      if (w_wr_fire && ap_idle_q) begin
        if (w_wr_addr == c_ADDR_LENGTH) length_q <= bus.wdata;
        if (w_wr_addr == c_ADDR_OFFSET) offset_q <= bus.wdata;
      end

      if (w_pop) count_q <= count_q + c_DATA_ONE;

      case (state_q)
        S_IDLE: begin
          if (w_wr_fire && w_wr_addr == c_ADDR_CTRL && bus.wdata[0]) begin
            state_q   <= S_RUN;
            ap_idle_q <= 1'b0;
            ap_done_q <= 1'b0;
            count_q   <= '0;
          end
        end
        S_RUN: begin
          if (w_push && bus.ss_tlast) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && w_head[pDATA_WIDTH]) begin
            state_q   <= S_IDLE;
            ap_idle_q <= 1'b1;
            ap_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_axil_axis_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axil_axis_responder : directed bench for axil_axis_responder      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_axil_axis_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] q_data [$];
  logic        q_last [$];
  logic [31:0] rd;

  always #5 clk = ~clk;

  axil_axis_responder_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  axil_axis_responder #(
    .pADDR_WIDTH(12),
    .pDATA_WIDTH(32),
    .pFIFO_DEPTH(4)
  ) dut (
    .axis_clk  (clk),
    .axis_rst_n(rst_n),
    .bus       (bus)
  );

  // Capture every output beat that will be popped on the next rising edge
  always @(negedge clk) begin
    if (rst_n && bus.sm_tvalid && bus.sm_tready) begin
      q_data.push_back(bus.sm_tdata);
      q_last.push_back(bus.sm_tlast);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    do begin
      step(1);
      n++;
    end while (!bus.awready && n < 10);
    check("aw_handshake", {31'b0, bus.awready}, 32'd1);
    check("w_ready_with_aw", {31'b0, bus.wready}, 32'd1);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
    int n;
    n = 0;
    while (!bus.arready && n < 10) begin
      step(1);
      n++;
    end
    check("ar_ready", {31'b0, bus.arready}, 32'd1);
    bus.araddr = a; bus.arvalid = 1'b1;
    step(1);
    bus.arvalid = 1'b0;
    check("r_valid_latency", {31'b0, bus.rvalid}, 32'd1);
    d = bus.rdata;
    bus.rready = 1'b1;
    step(1);
    bus.rready = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    bus.ss_tdata = d; bus.ss_tlast = l; bus.ss_tvalid = 1'b1;
    while (!bus.ss_tready && n < 50) begin
      step(1);
      n++;
    end
    check("ss_tready_wait", {31'b0, bus.ss_tready}, 32'd1);
    step(1);
    bus.ss_tvalid = 1'b0; bus.ss_tlast = 1'b0;
  endtask

  task automatic check_out(input int idx, input logic [31:0] exp_d, input logic exp_l);
    check($sformatf("out_data[%0d]", idx), (idx < q_data.size()) ? q_data[idx] : 32'hxxxxxxxx, exp_d);
    check($sformatf("out_last[%0d]", idx), {31'b0, (idx < q_last.size()) ? q_last[idx] : 1'bx}, {31'b0, exp_l});
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.ss_tvalid = 1'b0; bus.ss_tdata = '0; bus.ss_tlast = 1'b0; bus.sm_tready = 1'b0;

    // Reset state
    step(3);
    check("rst_awready", {31'b0, bus.awready}, 32'd0);
    check("rst_wready", {31'b0, bus.wready}, 32'd0);
    check("rst_arready", {31'b0, bus.arready}, 32'd0);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_ss_tready", {31'b0, bus.ss_tready}, 32'd0);
    check("rst_sm_tvalid", {31'b0, bus.sm_tvalid}, 32'd0);
    check("rst_sm_tdata", bus.sm_tdata, 32'd0);
    check("rst_sm_tlast", {31'b0, bus.sm_tlast}, 32'd0);
    rst_n = 1'b1;
    axil_read(12'h000, rd); check("ctrl_after_reset", rd, 32'h4);

    // Register access
    axil_write(12'h014, 32'h0000_0010);
    axil_write(12'h010, 32'h0000_0003);
    axil_read(12'h014, rd); check("offset_rb", rd, 32'h10);
    axil_read(12'h010, rd); check("length_rb", rd, 32'h3);
    axil_read(12'h020, rd); check("unmapped_rd", rd, 32'h0);
    axil_write(12'h020, 32'hDEAD_BEEF);
    axil_read(12'h020, rd); check("unmapped_wr_dropped", rd, 32'h0);
    axil_read(12'h314, rd); check("upper_addr_ignored", rd, 32'h10);
    bus.awaddr = 12'h010; bus.awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("aw_only_no_ready", {31'b0, bus.awready}, 32'd0);
    end
    bus.awvalid = 1'b0;
    step(1);

    // Basic run: 5,6,7 + 0x10
    bus.sm_tready = 1'b1;
    q_data.delete(); q_last.delete();
    axil_write(12'h000, 32'h1);
    check("run_ss_tready", {31'b0, bus.ss_tready}, 32'd1);
    send(32'd5, 1'b0);
    send(32'd6, 1'b0);
    send(32'd7, 1'b1);
    step(6);
    check("run1_out_count", q_data.size(), 32'd3);
    check_out(0, 32'h15, 1'b0);
    check_out(1, 32'h16, 1'b0);
    check_out(2, 32'h17, 1'b1);
    check("idle_ss_tready", {31'b0, bus.ss_tready}, 32'd0);
    axil_read(12'h018, rd); check("run1_count", rd, 32'd3);
    axil_read(12'h000, rd); check("ctrl_done", rd, 32'h6);
    axil_read(12'h000, rd); check("ctrl_done_cleared", rd, 32'h4);

    // Back-pressure: 6 samples with downstream stalled
    bus.sm_tready = 1'b0;
    q_data.delete(); q_last.delete();
    axil_write(12'h000, 32'h1);
    axil_read(12'h000, rd); check("ctrl_running", rd, 32'h0);
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
    check("full_ss_tready", {31'b0, bus.ss_tready}, 32'd0);
    check("full_sm_tvalid", {31'b0, bus.sm_tvalid}, 32'd1);
    check("full_head", bus.sm_tdata, 32'h11);
    bus.ss_tdata = 32'd5; bus.ss_tvalid = 1'b1;
    step(3);
    check("full_hold_ss_tready", {31'b0, bus.ss_tready}, 32'd0);
    check("stalled_no_output", q_data.size(), 32'd0);
    bus.sm_tready = 1'b1;
    send(32'd5, 1'b0);
    send(32'd6, 1'b1);
    step(8);
    check("run2_out_count", q_data.size(), 32'd6);
    for (int i = 0; i < 6; i++) check_out(i, 32'h11 + 32'(i), (i == 5));
    axil_read(12'h018, rd); check("run2_count", rd, 32'd6);
    axil_read(12'h000, rd); check("run2_done", rd, 32'h6);

    // Offset wrap and writes ignored while running
    axil_write(12'h014, 32'hFFFF_FFFF);
    q_data.delete(); q_last.delete();
    axil_write(12'h000, 32'h1);
    axil_write(12'h014, 32'h0000_0005);
    axil_write(12'h010, 32'h0000_0009);
    axil_read(12'h014, rd); check("offset_locked_in_run", rd, 32'hFFFF_FFFF);
    axil_read(12'h010, rd); check("length_locked_in_run", rd, 32'h3);
    send(32'd2, 1'b1);
    step(5);
    check("wrap_out_count", q_data.size(), 32'd1);
    check_out(0, 32'h1, 1'b1);
    axil_read(12'h000, rd); check("wrap_done", rd, 32'h6);

    // Reset with two samples buffered
    bus.sm_tready = 1'b0;
    q_data.delete(); q_last.delete();
    axil_write(12'h000, 32'h1);
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    check("buffered_valid", {31'b0, bus.sm_tvalid}, 32'd1);
    check("buffered_head", bus.sm_tdata, 32'h9);
    rst_n = 1'b0;
    step(1);
    check("midrst_sm_tvalid", {31'b0, bus.sm_tvalid}, 32'd0);
    check("midrst_ss_tready", {31'b0, bus.ss_tready}, 32'd0);
    check("midrst_sm_tdata", bus.sm_tdata, 32'd0);
    step(1);
    rst_n = 1'b1;
    bus.sm_tready = 1'b1;
    step(5);
    check("no_stale_out", q_data.size(), 32'd0);
    check("post_rst_sm_tvalid", {31'b0, bus.sm_tvalid}, 32'd0);
    axil_read(12'h000, rd); check("post_rst_ctrl", rd, 32'h4);
    axil_read(12'h014, rd); check("post_rst_offset", rd, 32'h0);
    axil_read(12'h018, rd); check("post_rst_count", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
